// File: rtl/slot_credit_dispatcher.sv
// slot_credit_dispatcher
//   Tracks the free-slot credits of every core and sends each packet request
//   to the enabled core that has the most free slots. A grant takes one
//   credit from the chosen core. A release from the core slot-return path
//   gives one credit back.
//
//   Optional build macro: SLOT_DISPATCH_STATS_EN
//     defined   -> grant_total / err_total are live 32-bit wrapping counters
//     undefined -> both outputs are tied to zero
//
// Ports
//   clk, rst_n     clock; asynchronous active-low reset
//   port_enable    per-port grant eligibility
//   req_valid/req_ready       request handshake from the packet scheduler
//   grant_valid/grant_ready   grant handshake; grant_port is the chosen core
//   release_valid/release_port one credit returned by a core
//   release_err    1-cycle pulse when a release hits a counter that is already full
//   free_count     all counters flattened, port 0 in the LSBs
//   grant_total, err_total    statistics
module slot_credit_dispatcher #(
  parameter int PORT_COUNT = 16,
  parameter int SLOT_WIDTH = 8,
  parameter int MAX_SLOTS  = 16,
  parameter int ADDR_WIDTH = $clog2(PORT_COUNT)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PORT_COUNT-1:0]            port_enable,
  input  logic                             req_valid,
  output logic                             req_ready,
  output logic                             grant_valid,
  input  logic                             grant_ready,
  output logic [ADDR_WIDTH-1:0]            grant_port,
  input  logic                             release_valid,
  input  logic [ADDR_WIDTH-1:0]            release_port,
  output logic                             release_err,
  output logic [PORT_COUNT*SLOT_WIDTH-1:0] free_count,
  output logic [31:0]                      grant_total,
  output logic [31:0]                      err_total
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_GRANT} state_e;

  localparam logic [SLOT_WIDTH-1:0] MAX_V = SLOT_WIDTH'(MAX_SLOTS);

  state_e                  state_q;
  logic                    req_ready_q;
  logic                    grant_valid_q;
  logic [ADDR_WIDTH-1:0]   grant_port_q;

  logic [SLOT_WIDTH-1:0]   cnt_q [PORT_COUNT];
  logic [SLOT_WIDTH-1:0]   cnt_d [PORT_COUNT];
  logic [SLOT_WIDTH-1:0]   sel_val_q, sel_val_d;
  logic [ADDR_WIDTH-1:0]   sel_ptr_q, sel_ptr_d;
  logic                    release_err_q, release_err_d;

  logic [PORT_COUNT-1:0]   inc_v, dec_v;
  logic                    grant_fire;
  logic                    rel_hit;

  // Argmax over the enabled counters. A disabled port counts as zero. The
  // strict '>' makes ties go to the lowest index.
  always_comb begin
    sel_val_d = '0;
    sel_ptr_d = '0;
    for (int unsigned i = 0; i < PORT_COUNT; i++) begin
      if (port_enable[i] && (cnt_q[i] > sel_val_d)) begin
        sel_val_d = cnt_q[i];
        sel_ptr_d = ADDR_WIDTH'(i);
      end
    end
  end

  // The selection is one cycle old. Check the chosen port again against the
  // live enable and the live counter before granting it.
  assign grant_fire = (state_q == ST_SEARCH) && (sel_val_q != '0) &&
                      port_enable[sel_ptr_q] && (cnt_q[sel_ptr_q] != '0);

  assign rel_hit = release_valid && (32'(release_port) < 32'(PORT_COUNT));

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int unsigned i = 0; i < PORT_COUNT; i++) begin
      inc_v[i] = rel_hit && (release_port == ADDR_WIDTH'(i));
      dec_v[i] = grant_fire && (sel_ptr_q == ADDR_WIDTH'(i));
    end
  end

  // A grant and a release on the same port in the same cycle cancel out.
  // Because nothing is added, that case does not count as an overflow.
  always_comb begin
    release_err_d = 1'b0;
    for (int unsigned i = 0; i < PORT_COUNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_v[i] && !dec_v[i]) begin
        if (cnt_q[i] == MAX_V) release_err_d = 1'b1;
        else                   cnt_d[i] = cnt_q[i] + SLOT_WIDTH'(1);
      end else if (dec_v[i] && !inc_v[i]) begin
        cnt_d[i] = cnt_q[i] - SLOT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PORT_COUNT; i++) cnt_q[i] <= MAX_V;
      sel_val_q     <= '0;
      sel_ptr_q     <= '0;
      release_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < PORT_COUNT; i++) cnt_q[i] <= cnt_d[i];
      sel_val_q     <= sel_val_d;
      sel_ptr_q     <= sel_ptr_d;
      release_err_q <= release_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b0;
      grant_valid_q <= 1'b0;
      grant_port_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // req_ready rises on the first clock after reset.
          if (req_valid && req_ready_q) begin
            state_q     <= ST_SEARCH;
            req_ready_q <= 1'b0;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_SEARCH: begin
          if (grant_fire) begin
            grant_valid_q <= 1'b1;
            grant_port_q  <= sel_ptr_q;
            state_q       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (grant_ready) begin
            grant_valid_q <= 1'b0;
            req_ready_q   <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          req_ready_q   <= 1'b0;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign grant_valid = grant_valid_q;
  assign grant_port  = grant_port_q;
  assign release_err = release_err_q;

  always_comb begin
    free_count = '0;
    for (int unsigned i = 0; i < PORT_COUNT; i++)
      free_count[i*SLOT_WIDTH +: SLOT_WIDTH] = cnt_q[i];
  end

`ifdef SLOT_DISPATCH_STATS_EN
  logic [31:0] grant_total_q, err_total_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_total_q <= '0;
      err_total_q   <= '0;
    end else begin
      if (grant_fire)    grant_total_q <= grant_total_q + 32'd1;
      if (release_err_d) err_total_q   <= err_total_q + 32'd1;
    end
  end

  assign grant_total = grant_total_q;
  assign err_total   = err_total_q;
`else
  assign grant_total = '0;
  assign err_total   = '0;
`endif

endmodule

// File: tb/tb_slot_credit_dispatcher.sv
// Directed testbench for slot_credit_dispatcher (4 ports, 4 slots per port).
// Each request pushes its expected grant port into a queue. A separate
// monitor pops one entry and compares it on every grant handshake.
module tb_slot_credit_dispatcher;

  localparam int PC = 4;
  localparam int SW = 8;
  localparam int MS = 4;
  localparam int AW = 2;

`ifdef SLOT_DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [PC-1:0]    port_enable;
  logic             req_valid;
  logic             req_ready;
  logic             grant_valid;
  logic             grant_ready;
  logic [AW-1:0]    grant_port;
  logic             release_valid;
  logic [AW-1:0]    release_port;
  logic             release_err;
  logic [PC*SW-1:0] free_count;
  logic [31:0]      grant_total;
  logic [31:0]      err_total;

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mon_exp;

  slot_credit_dispatcher #(
    .PORT_COUNT(PC),
    .SLOT_WIDTH(SW),
    .MAX_SLOTS (MS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .port_enable  (port_enable),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .grant_valid  (grant_valid),
    .grant_ready  (grant_ready),
    .grant_port   (grant_port),
    .release_valid(release_valid),
    .release_port (release_port),
    .release_err  (release_err),
    .free_count   (free_count),
    .grant_total  (grant_total),
    .err_total    (err_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && grant_valid && grant_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL grant_unexpected: got port %0d, expected no grant", grant_port);
      end else begin
        mon_exp = exp_q.pop_front();
        check("grant_port", 32'(grant_port), 32'(mon_exp));
      end
    end
  end

  task automatic do_reset();
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    release_valid = 1'b0;
    release_port  = '0;
    grant_ready   = 1'b1;
    port_enable   = 4'hF;
    exp_q.delete();
    @(negedge clk);
    check("rst_req_ready",   32'(req_ready),   32'd0);
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_grant_port",  32'(grant_port),  32'd0);
    check("rst_release_err", 32'(release_err), 32'd0);
    check("rst_free_count",  free_count,       32'h04040404);
    check("rst_grant_total", grant_total,      32'd0);
    check("rst_err_total",   err_total,        32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Returns 1 ns after the clock edge that accepted the request,
  // which is the first SEARCH cycle.
  task automatic send_req(input logic [AW-1:0] exp);
    int unsigned k;
    exp_q.push_back(exp);
    req_valid = 1'b1;
    k = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready) break;
      k++;
      if (k > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL req_ready_timeout: req_ready still 0 after 50 cycles, expected 1");
        break;
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_grant();
    int unsigned k;
    k = 0;
    while (1) begin
      @(negedge clk);
      if (grant_valid && grant_ready) break;
      k++;
      if (k > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL grant_timeout: no grant handshake within 50 cycles, expected one");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic stalled;
    int unsigned k;

    // 1: first grant latency and credit decrement
    do_reset();
    send_req(2'd0);
    @(negedge clk);
    check("lat_cycle1_grant_valid", 32'(grant_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_grant_valid", 32'(grant_valid), 32'd1);
    check("t1_free_count", free_count, 32'h04040403);
    @(posedge clk);
    #1;

    // 2: five back-to-back requests; ties go to the lowest index
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_req(AW'(i % PC));
      wait_grant();
    end
    check("t2_free_count", free_count, 32'h03030302);
    check("t2_grant_total", grant_total, STATS ? 32'd5 : 32'd0);

    // 3: drain every credit, stall in SEARCH, then a release unblocks the request
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send_req(AW'(i % PC));
      wait_grant();
    end
    check("t3_drained", free_count, 32'h00000000);
    send_req(2'd2);
    stalled = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (grant_valid) stalled = 1'b0;
    end
    check("t3_search_stall", 32'(stalled), 32'd1);
    @(posedge clk);
    #1;
    release_valid = 1'b1;
    release_port  = 2'd2;
    @(posedge clk);
    #1 release_valid = 1'b0;
    wait_grant();
    check("t3_after_release", free_count, 32'h00000000);

    // 4: masked ports are never granted
    do_reset();
    port_enable = 4'b1010;
    send_req(2'd1); wait_grant();
    send_req(2'd3); wait_grant();
    send_req(2'd1); wait_grant();
    send_req(2'd3); wait_grant();
    check("t4_free_count", free_count, 32'h02040204);
    port_enable = 4'hF;

    // 5: release to a full counter
    do_reset();
    release_valid = 1'b1;
    release_port  = 2'd1;
    @(posedge clk);
    #1 release_valid = 1'b0;
    @(negedge clk);
    check("t5_release_err_pulse", 32'(release_err), 32'd1);
    check("t5_free_count", free_count, 32'h04040404);
    check("t5_err_total", err_total, STATS ? 32'd1 : 32'd0);
    @(negedge clk);
    check("t5_release_err_clear", 32'(release_err), 32'd0);
    @(posedge clk);
    #1;

    // 6: release and grant on the same port in the same cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_req(AW'(i));
      wait_grant();
    end
    send_req(2'd0);
    release_valid = 1'b1;
    release_port  = 2'd0;
    @(posedge clk);
    #1 release_valid = 1'b0;
    wait_grant();
    check("t6_same_cycle_free", free_count, 32'h03030303);
    check("t6_grant_total", grant_total, STATS ? 32'd5 : 32'd0);

    // 6b: asynchronous reset while a grant is outstanding
    grant_ready = 1'b0;
    send_req(2'd0);
    k = 0;
    while (!grant_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t6_grant_held", 32'(grant_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_grant_valid", 32'(grant_valid), 32'd0);
    check("t6_async_free", free_count, 32'h04040404);
    check("t6_async_req_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    grant_ready = 1'b1;
    send_req(2'd0);
    wait_grant();
    check("t6_recover_free", free_count, 32'h04040403);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
